// File: rtl/aes_result_checker.sv
// aes_result_checker
//   Board-level self-test stage behind the AES SPI master. It captures the
//   ciphertext on done_enc and the round-trip plaintext on done_dec. It checks
//   the round trip, and the ciphertext when ct_check_en is set. It issues one
//   verdict per transaction, or a timeout verdict if the awaited pulse never
//   arrives, and keeps saturating pass/fail tallies.
//
// Ports
//   clk            divided SPI clock, all logic on posedge
//   rst            synchronous active-high reset
//   data_in        plaintext currently driven into the master
//   expected_ct    expected ciphertext for data_in/key
//   ct_check_en    1 = ciphertext must match expected_ct (sampled in REPORT)
//   done_enc       1-cycle pulse, data_out holds ciphertext
//   done_dec       1-cycle pulse, data_out holds decrypted text
//   data_out       master result bus
//   ciphertext     last captured ciphertext
//   plaintext_out  last captured decryption result
//   result_valid   1-cycle pulse per verdict
//   pass/fail      held verdict of the last transaction
//   timeout        last verdict came from a timeout
//   pass_count     saturating pass tally
//   fail_count     saturating fail tally (timeouts included)
//   busy           1 while waiting for done_dec
//
// state    | meaning
// ---------+---------------------------------------------------------------
// WAIT_ENC | idle, waiting for a ciphertext (reset state)
// WAIT_DEC | ciphertext captured, waiting for the round-trip plaintext
// REPORT   | one cycle, verdict computed and registered
module aes_result_checker #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic [127:0] expected_ct,
  input  logic         ct_check_en,
  input  logic         done_enc,
  input  logic         done_dec,
  input  logic [127:0] data_out,
  output logic [127:0] ciphertext,
  output logic [127:0] plaintext_out,
  output logic         result_valid,
  output logic         pass,
  output logic         fail,
  output logic         timeout,
  output logic [7:0]   pass_count,
  output logic [7:0]   fail_count,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_WAIT_ENC = 2'd0,
    S_WAIT_DEC = 2'd1,
    S_REPORT   = 2'd2
  } state_t;

  // The timer counts down from TIMEOUT-1 and fires at zero. This is the same
  // cycle count as an up-counter that fires when it reaches TIMEOUT-1.
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [15:0]    tmr_q, tmr_d;
  logic           armed_q, armed_d;   // a verdict has been issued since reset
  logic [127:0]   ciphertext_q, ciphertext_d;
  logic [127:0]   plaintext_q, plaintext_d;
  logic [127:0]   pt_ref_q, pt_ref_d;
  logic           ct_ok_q, ct_ok_d;
  logic           pt_ok_q, pt_ok_d;
  logic           result_valid_q, result_valid_d;
  logic           pass_q, pass_d;
  logic           fail_q, fail_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     pass_count_q, pass_count_d;
  logic [7:0]     fail_count_q, fail_count_d;
  logic           busy_q, busy_d;
  logic           verdict_pass;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  assign verdict_pass = pt_ok_q & (ct_ok_q | ~ct_check_en);

  always_comb begin
    state_d        = state_q;
    tmr_d          = tmr_q;
    armed_d        = armed_q;
    ciphertext_d   = ciphertext_q;
    plaintext_d    = plaintext_q;
    pt_ref_d       = pt_ref_q;
    ct_ok_d        = ct_ok_q;
    pt_ok_d        = pt_ok_q;
    result_valid_d = 1'b0;
    pass_d         = pass_q;
    fail_d         = fail_q;
    timeout_d      = timeout_q;
    pass_count_d   = pass_count_q;
    fail_count_d   = fail_count_q;

    case (state_q)
      S_WAIT_ENC: begin
        if (done_enc) begin
          ciphertext_d = data_out;
          pt_ref_d     = data_in;
          ct_ok_d      = (data_out == expected_ct);
          tmr_d        = TMR_LOAD;
          state_d      = S_WAIT_DEC;
        end else if (armed_q) begin
          // Idle timeout only runs once the block has issued a first verdict.
          if (tmr_q == 16'd0) begin
            result_valid_d = 1'b1;
            pass_d         = 1'b0;
            fail_d         = 1'b1;
            timeout_d      = 1'b1;
            fail_count_d   = sat_inc(fail_count_q);
            tmr_d          = TMR_LOAD;
          end else begin
            tmr_d = tmr_q - 16'd1;
          end
        end
      end

      S_WAIT_DEC: begin
        // done_enc has priority: a same-cycle done_dec belongs to the
        // abandoned transaction.
        if (done_enc) begin
          ciphertext_d = data_out;
          pt_ref_d     = data_in;
          ct_ok_d      = (data_out == expected_ct);
          tmr_d        = TMR_LOAD;
        end else if (done_dec) begin
          plaintext_d = data_out;
          pt_ok_d     = (data_out == pt_ref_q);
          state_d     = S_REPORT;
        end else if (tmr_q == 16'd0) begin
          result_valid_d = 1'b1;
          pass_d         = 1'b0;
          fail_d         = 1'b1;
          timeout_d      = 1'b1;
          fail_count_d   = sat_inc(fail_count_q);
          tmr_d          = TMR_LOAD;
          armed_d        = 1'b1;
          state_d        = S_WAIT_ENC;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end

      S_REPORT: begin
        result_valid_d = 1'b1;
        pass_d         = verdict_pass;
        fail_d         = ~verdict_pass;
        timeout_d      = 1'b0;
        if (verdict_pass) pass_count_d = sat_inc(pass_count_q);
        else              fail_count_d = sat_inc(fail_count_q);
        tmr_d          = TMR_LOAD;
        armed_d        = 1'b1;
        state_d        = S_WAIT_ENC;
      end

      default: begin
        state_d = S_WAIT_ENC;
      end
    endcase

    busy_d = (state_d == S_WAIT_DEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_WAIT_ENC;
      tmr_q          <= 16'd0;
      armed_q        <= 1'b0;
      ciphertext_q   <= '0;
      plaintext_q    <= '0;
      pt_ref_q       <= '0;
      ct_ok_q        <= 1'b0;
      pt_ok_q        <= 1'b0;
      result_valid_q <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      pass_count_q   <= 8'd0;
      fail_count_q   <= 8'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      armed_q        <= armed_d;
      ciphertext_q   <= ciphertext_d;
      plaintext_q    <= plaintext_d;
      pt_ref_q       <= pt_ref_d;
      ct_ok_q        <= ct_ok_d;
      pt_ok_q        <= pt_ok_d;
      result_valid_q <= result_valid_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      timeout_q      <= timeout_d;
      pass_count_q   <= pass_count_d;
      fail_count_q   <= fail_count_d;
      busy_q         <= busy_d;
    end
  end

  assign ciphertext    = ciphertext_q;
  assign plaintext_out = plaintext_q;
  assign result_valid  = result_valid_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign pass_count    = pass_count_q;
  assign fail_count    = fail_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_aes_result_checker.sv
// Directed, table-driven bench for aes_result_checker with TIMEOUT = 1024.
module tb_aes_result_checker;

  logic         clk;
  logic         rst;
  logic [127:0] data_in;
  logic [127:0] expected_ct;
  logic         ct_check_en;
  logic         done_enc;
  logic         done_dec;
  logic [127:0] data_out;
  logic [127:0] ciphertext;
  logic [127:0] plaintext_out;
  logic         result_valid;
  logic         pass;
  logic         fail;
  logic         timeout;
  logic [7:0]   pass_count;
  logic [7:0]   fail_count;
  logic         busy;

  aes_result_checker #(.TIMEOUT(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .expected_ct   (expected_ct),
    .ct_check_en   (ct_check_en),
    .done_enc      (done_enc),
    .done_dec      (done_dec),
    .data_out      (data_out),
    .ciphertext    (ciphertext),
    .plaintext_out (plaintext_out),
    .result_valid  (result_valid),
    .pass          (pass),
    .fail          (fail),
    .timeout       (timeout),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PTX  = 128'h00112233445566778899aabbccddeefe;
  localparam logic [127:0] PT1  = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [127:0] CT1  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ct_bus;
    logic [127:0] exp_ct;
    logic [127:0] dec_bus;
    logic         en_cap;
    logic         en_rep;
    int           gap;
    logic         exp_pass;
  } vec_t;

  vec_t vecs [9];

  int n_chk = 0;
  int n_err = 0;
  int rv_cnt = 0;
  int exp_pc = 0;
  int exp_fc = 0;
  logic [127:0] last_pt;
  logic [127:0] last_ct;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (result_valid === 1'b1) rv_cnt++;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check_counts(input string tag);
    chk({tag, ".pass_count"}, {120'd0, pass_count}, 128'(exp_pc));
    chk({tag, ".fail_count"}, {120'd0, fail_count}, 128'(exp_fc));
  endtask

  // Count edges from now until result_valid is seen, bounded.
  task automatic wait_rv(input int limit, output int cycles);
    cycles = 0;
    while (cycles < limit) begin
      tick();
      cycles++;
      if (result_valid === 1'b1) return;
    end
    cycles = -1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    data_in     = v.pt;
    expected_ct = v.exp_ct;
    ct_check_en = v.en_cap;
    data_out    = v.ct_bus;
    done_enc    = 1'b1;
    tick();
    done_enc = 1'b0;
    data_out = '0;
    data_in  = ~v.pt;                // pt_ref must hold the captured value
    chk($sformatf("v%0d.busy_after_enc", i), {127'd0, busy}, 128'd1);
    chk($sformatf("v%0d.ciphertext", i), ciphertext, v.ct_bus);
    repeat (v.gap - 1) tick();
    done_dec    = 1'b1;
    data_out    = v.dec_bus;
    ct_check_en = v.en_rep;
    tick();
    done_dec = 1'b0;
    data_out = '0;
    chk($sformatf("v%0d.rv_early", i), {127'd0, result_valid}, 128'd0);
    chk($sformatf("v%0d.busy_report", i), {127'd0, busy}, 128'd0);
    tick();
    if (v.exp_pass) exp_pc = sat(exp_pc + 1);
    else            exp_fc = sat(exp_fc + 1);
    chk($sformatf("v%0d.rv", i), {127'd0, result_valid}, 128'd1);
    chk($sformatf("v%0d.pass", i), {127'd0, pass}, {127'd0, v.exp_pass});
    chk($sformatf("v%0d.fail", i), {127'd0, fail}, {127'd0, ~v.exp_pass});
    chk($sformatf("v%0d.timeout", i), {127'd0, timeout}, 128'd0);
    chk($sformatf("v%0d.plaintext_out", i), plaintext_out, v.dec_bus);
    check_counts($sformatf("v%0d", i));
    tick();
    chk($sformatf("v%0d.rv_one_cycle", i), {127'd0, result_valid}, 128'd0);
    last_pt = v.dec_bus;
    last_ct = v.ct_bus;
  endtask

  initial begin
    int cyc;
    int rv0;

    //            pt    ct_bus exp_ct dec_bus en_cap en_rep gap  exp_pass
    vecs[0] = '{PT0, CT0, CT0,   PT0, 1'b1, 1'b1, 389, 1'b1};
    vecs[1] = '{PT0, CT0, '0,    PT0, 1'b1, 1'b1, 389, 1'b0};
    vecs[2] = '{PT0, CT0, '0,    PT0, 1'b0, 1'b0, 389, 1'b1};
    vecs[3] = '{PT0, CT0, CT0,   PTX, 1'b1, 1'b1, 389, 1'b0};
    vecs[4] = '{PT0, CT0, '0,    PTX, 1'b0, 1'b0, 20,  1'b0};
    vecs[5] = '{PT1, CT1, CT1,   PT1, 1'b1, 1'b1, 3,   1'b1};
    vecs[6] = '{PT1, CT1, '0,    PT1, 1'b1, 1'b0, 5,   1'b1};  // en off at REPORT
    vecs[7] = '{PT1, CT1, '0,    PT1, 1'b0, 1'b1, 5,   1'b0};  // en on at REPORT
    vecs[8] = '{PT0, CT0, CT0,   PT0, 1'b1, 1'b1, 1,   1'b1};  // back-to-back pulses

    rst = 1'b1;
    data_in = '0; expected_ct = '0; ct_check_en = 1'b0;
    done_enc = 1'b0; done_dec = 1'b0; data_out = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst.ciphertext", ciphertext, 128'd0);
    chk("rst.plaintext_out", plaintext_out, 128'd0);
    chk("rst.outs", {123'd0, result_valid, pass, fail, timeout, busy}, 128'd0);
    check_counts("rst");

    // done_dec while idle is ignored
    rv0 = rv_cnt;
    done_dec = 1'b1; data_out = PT0;
    tick();
    done_dec = 1'b0; data_out = '0;
    repeat (3) tick();
    chk("idle_dec.no_verdict", 128'(rv_cnt - rv0), 128'd0);
    chk("idle_dec.plaintext_out", plaintext_out, 128'd0);
    chk("idle_dec.busy", {127'd0, busy}, 128'd0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Timeout in WAIT_DEC
    data_in = PT1; expected_ct = CT1; ct_check_en = 1'b1;
    data_out = CT1; done_enc = 1'b1;
    tick();
    done_enc = 1'b0; data_out = '0;
    wait_rv(2000, cyc);
    exp_fc = sat(exp_fc + 1);
    chk("to_dec.cycles", 128'(cyc), 128'd1024);
    chk("to_dec.flags", {125'd0, pass, fail, timeout}, 128'b011);
    chk("to_dec.busy", {127'd0, busy}, 128'd0);
    chk("to_dec.ciphertext", ciphertext, CT1);
    chk("to_dec.plaintext_out", plaintext_out, last_pt);
    check_counts("to_dec");

    // Idle timeout in WAIT_ENC once a verdict has been issued
    wait_rv(2000, cyc);
    exp_fc = sat(exp_fc + 1);
    chk("to_enc.cycles", 128'(cyc), 128'd1024);
    chk("to_enc.flags", {125'd0, pass, fail, timeout}, 128'b011);
    check_counts("to_enc");
    tick();

    // Same-cycle done_enc + done_dec in WAIT_DEC restarts
    data_in = PT0; expected_ct = CT0; ct_check_en = 1'b1;
    data_out = CT1; done_enc = 1'b1;
    tick();
    done_enc = 1'b0; data_out = '0;
    tick();
    rv0 = rv_cnt;
    done_enc = 1'b1; done_dec = 1'b1; data_out = CT0;
    tick();
    done_enc = 1'b0; done_dec = 1'b0; data_out = '0;
    chk("restart.busy", {127'd0, busy}, 128'd1);
    chk("restart.ciphertext", ciphertext, CT0);
    repeat (2) tick();
    chk("restart.no_verdict", 128'(rv_cnt - rv0), 128'd0);
    done_dec = 1'b1; data_out = PT0;
    tick();
    done_dec = 1'b0; data_out = '0;
    tick();
    exp_pc = sat(exp_pc + 1);
    chk("restart.verdict", {124'd0, result_valid, pass, fail, timeout}, 128'b1100);
    check_counts("restart");
    tick();

    // done_enc during REPORT is dropped
    data_in = PT1; expected_ct = CT1; ct_check_en = 1'b1;
    data_out = CT1; done_enc = 1'b1;
    tick();
    done_enc = 1'b0; data_out = '0;
    done_dec = 1'b1; data_out = PT1;
    tick();
    done_dec = 1'b0;
    done_enc = 1'b1; data_out = CT0;   // lands in REPORT
    tick();
    done_enc = 1'b0; data_out = '0;
    exp_pc = sat(exp_pc + 1);
    chk("drop.verdict", {124'd0, result_valid, pass, fail, timeout}, 128'b1100);
    chk("drop.ciphertext", ciphertext, CT1);
    tick();
    chk("drop.busy", {127'd0, busy}, 128'd0);
    check_counts("drop");

    // 300 passing transactions: pass_count saturates
    rv0 = rv_cnt;
    for (int i = 0; i < 300; i++) begin
      data_in = PT1; expected_ct = CT1; ct_check_en = 1'b1;
      data_out = CT1; done_enc = 1'b1;
      tick();
      done_enc = 1'b0;
      done_dec = 1'b1; data_out = PT1;
      tick();
      done_dec = 1'b0; data_out = '0;
      repeat (2) tick();
      exp_pc = sat(exp_pc + 1);
    end
    chk("sat.verdicts", 128'(rv_cnt - rv0), 128'd300);
    chk("sat.pass_count", {120'd0, pass_count}, 128'd255);
    check_counts("sat");

    // Reset mid WAIT_DEC, with a same-cycle done_dec that must be lost
    data_in = PT0; expected_ct = CT0; ct_check_en = 1'b1;
    data_out = CT0; done_enc = 1'b1;
    tick();
    done_enc = 1'b0; data_out = '0;
    repeat (3) tick();
    rst = 1'b1; done_dec = 1'b1; data_out = PT0;
    tick();
    rst = 1'b0; done_dec = 1'b0; data_out = '0;
    exp_pc = 0; exp_fc = 0;
    chk("midrst.outs", {123'd0, result_valid, pass, fail, timeout, busy}, 128'd0);
    chk("midrst.ciphertext", ciphertext, 128'd0);
    chk("midrst.plaintext_out", plaintext_out, 128'd0);
    check_counts("midrst");
    rv0 = rv_cnt;
    done_dec = 1'b1; data_out = PT0;
    tick();
    done_dec = 1'b0; data_out = '0;
    repeat (3) tick();
    chk("midrst.dec_ignored", 128'(rv_cnt - rv0), 128'd0);
    check_counts("midrst_after");

    // Reset beats a same-cycle done_enc
    rst = 1'b1; done_enc = 1'b1; data_out = CT1;
    tick();
    rst = 1'b0; done_enc = 1'b0; data_out = '0;
    chk("rst_enc.busy", {127'd0, busy}, 128'd0);
    chk("rst_enc.ciphertext", ciphertext, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
